cam_capture: RTL and testbench

// Camera-side capture stage feeding the frame buffer / zone detector.

---
 rtl/cam_capture_if.sv | 24 ++
 rtl/cam_capture.sv | 138 +++++++++++++
 tb/tb_cam_capture.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_if.sv
// Camera byte bus in, frame-buffer write port and frame status out.
// The write port has no back-pressure: a stored pixel is written in the single cycle where we=1.
interface cam_capture_if;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        we;
  logic [16:0] wAddr;
  logic [15:0] wData;
  logic        led_clear;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        overflow;

  modport master (
    output vsync, href, d,
    input  we, wAddr, wData, led_clear, frame_done, frame_cnt, overflow
  );

  modport slave (
    input  vsync, href, d,
    output we, wAddr, wData, led_clear, frame_done, frame_cnt, overflow
  );
endinterface

// File: rtl/cam_capture.sv
// Pairs camera bytes into RGB565 pixels, decimates to W x H and writes them
// sequentially into the frame buffer, with per-frame clear/done strobes.
module cam_capture #(
  parameter int SRC_W = 640,
  parameter int SRC_H = 480,
  parameter int W     = 320,
  parameter int H     = 240,
  parameter int DEC   = 2
) (
  input  logic          pclk,
  input  logic          reset,
  cam_capture_if.slave  bus,
  output logic          o_dbg_state
);
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(NPIX + 1);
  localparam int XW   = $clog2(SRC_W + 1);
  localparam int YW   = $clog2(SRC_H + 1);
  localparam logic [AW-1:0] ADDR_END = AW'(NPIX);
  localparam logic [XW-1:0] X_END    = XW'(SRC_W);
  localparam logic [YW-1:0] Y_END    = YW'(SRC_H);

  typedef enum logic {WAIT_SYNC = 1'b0, FRAME = 1'b1} state_t;

  state_t          r_state, w_state_next;
  logic            w_in_frame;
  logic            r_vsync_q, r_href_q, r_phase, r_clear_pend, r_frame_ovf;
  logic [7:0]      r_hi;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [AW-1:0]   r_addr;
  logic            r_we, r_led_clear, r_frame_done, r_overflow;
  logic [AW-1:0]   r_waddr;
  logic [15:0]     r_wdata;
  logic [7:0]      r_frame_cnt;

  logic w_rise, w_sample, w_pix, w_keep_x, w_keep_y, w_keep;
  logic w_store, w_ovf, w_boundary, w_line_end, w_frame_ok;

  always_comb begin
    w_state_next = r_state;
    w_in_frame   = 1'b0;
    case (r_state)
      WAIT_SYNC: if (w_rise) w_state_next = FRAME;
      FRAME: begin
        w_in_frame   = 1'b1;
        w_state_next = FRAME;
      end
      default: w_state_next = WAIT_SYNC;
    endcase
  end

  assign w_rise     = bus.vsync & ~r_vsync_q;
  assign w_sample   = w_in_frame & bus.href;
  assign w_pix      = w_sample & r_phase;
  assign w_keep_x   = (DEC == 1) ? 1'b1 : ~r_x[0];
  assign w_keep_y   = (DEC == 1) ? 1'b1 : ~r_y[0];
  assign w_keep     = w_pix & (r_x < X_END) & (r_y < Y_END) & w_keep_x & w_keep_y;
  assign w_store    = w_keep & (r_addr != ADDR_END);
  assign w_ovf      = w_keep & (r_addr == ADDR_END);
  // A rise that coincides with a store is deferred one cycle so the store
  // keeps its address and led_clear never overlaps we.
  assign w_boundary = (w_rise & ~w_store) | r_clear_pend;
  assign w_line_end = w_in_frame & r_href_q & ~bus.href;
  assign w_frame_ok = w_in_frame & (r_addr == ADDR_END) & ~r_frame_ovf & ~w_ovf;

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state      <= WAIT_SYNC;
      r_vsync_q    <= 1'b1;
      r_href_q     <= 1'b0;
      r_phase      <= 1'b0;
      r_clear_pend <= 1'b0;
      r_frame_ovf  <= 1'b0;
      r_hi         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_led_clear  <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_vsync_q    <= bus.vsync;
      r_href_q     <= bus.href;
      r_we         <= w_store;
      r_led_clear  <= w_boundary;
      r_frame_done <= 1'b0;
      r_clear_pend <= w_rise & w_store;

      if (w_sample) r_phase <= ~r_phase;
      else          r_phase <= 1'b0;
      if (w_sample && !r_phase) r_hi <= bus.d;
      if (w_pix && (r_x < X_END)) r_x <= r_x + XW'(1);

      if (w_store) begin
        r_wdata <= {r_hi, bus.d};
        r_waddr <= r_addr;
        r_addr  <= r_addr + AW'(1);
      end
      if (w_ovf) begin
        r_overflow  <= 1'b1;
        r_frame_ovf <= 1'b1;
      end

      if (w_line_end) begin
        r_x <= '0;
        if (r_y < Y_END) r_y <= r_y + YW'(1);
      end

      // Frame boundary wins over line end and pixel counters.
      if (w_boundary) begin
        r_addr      <= '0;
        r_x         <= '0;
        r_y         <= '0;
        r_phase     <= 1'b0;
        r_frame_ovf <= 1'b0;
        if (w_frame_ok) begin
          r_frame_done <= 1'b1;
          r_frame_cnt  <= r_frame_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.we         = r_we;
  assign bus.wAddr      = 17'(r_waddr);
  assign bus.wData      = r_wdata;
  assign bus.led_clear  = r_led_clear;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.overflow   = r_overflow;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: two small instances (DEC=2 and an undersized DEC=1
// buffer) driven by line-level tasks and checked against a pixel-level model.
module tb_cam_capture;
  logic       pclk = 1'b0;
  logic       rst_a, rst_b, sel;
  logic       vsync, href;
  logic [7:0] d;
  logic       dbg_a, dbg_b;

  cam_capture_if ifa();
  cam_capture_if ifb();
  assign ifa.vsync = vsync;
  assign ifa.href  = href;
  assign ifa.d     = d;
  assign ifb.vsync = vsync;
  assign ifb.href  = href;
  assign ifb.d     = d;

  cam_capture #(.SRC_W(16), .SRC_H(12), .W(8), .H(6), .DEC(2)) dut_a (
    .pclk(pclk), .reset(rst_a), .bus(ifa.slave), .o_dbg_state(dbg_a));
  cam_capture #(.SRC_W(8), .SRC_H(8), .W(8), .H(4), .DEC(1)) dut_b (
    .pclk(pclk), .reset(rst_b), .bus(ifb.slave), .o_dbg_state(dbg_b));

  // clock / observed-output mux
  always #5 pclk = ~pclk;

  logic        mw, mlc, mfd, movf;
  logic [16:0] mad;
  logic [15:0] mda;
  logic [7:0]  mcnt;
  assign mw   = sel ? ifb.we         : ifa.we;
  assign mlc  = sel ? ifb.led_clear  : ifa.led_clear;
  assign mfd  = sel ? ifb.frame_done : ifa.frame_done;
  assign movf = sel ? ifb.overflow   : ifa.overflow;
  assign mad  = sel ? ifb.wAddr      : ifa.wAddr;
  assign mda  = sel ? ifb.wData      : ifa.wData;
  assign mcnt = sel ? ifb.frame_cnt  : ifa.frame_cnt;

  // scoreboard state
  logic [32:0] exp_q[$];
  int          exp_t[$];
  int          lc_t[$];
  bit          lc_fd[$];
  logic [7:0]  lc_cnt[$];

  int          p_srcw, p_srch, p_dec, p_npix;
  int          m_addr, m_y;
  bit          m_in_frame, m_frame_ovf, m_wrote;
  logic [7:0]  m_cnt;

  int          total = 0, bad = 0, ncyc = 0, nwe = 0, nlc = 0;
  logic [16:0] last_addr = '0;
  logic [15:0] last_data = '0;
  logic [7:0]  line_buf[64];
  bit          mon_exp_we, mon_exp_lc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // compare process: every cycle
  always @(negedge pclk) begin
    ncyc++;
    mon_exp_we = (exp_t.size() > 0) && (exp_t[0] == ncyc);
    chk("we", 32'(mw), 32'(mon_exp_we));
    if (mon_exp_we) begin
      chk("wAddr", 32'(mad), 32'(exp_q[0][32:16]));
      chk("wData", 32'(mda), 32'(exp_q[0][15:0]));
      void'(exp_q.pop_front());
      void'(exp_t.pop_front());
    end
    if (mw) begin
      nwe++;
      last_addr = mad;
      last_data = mda;
    end
    mon_exp_lc = (lc_t.size() > 0) && (lc_t[0] == ncyc);
    chk("led_clear", 32'(mlc), 32'(mon_exp_lc));
    chk("frame_done", 32'(mfd), mon_exp_lc ? 32'(lc_fd[0]) : 32'd0);
    if (mon_exp_lc) begin
      chk("frame_cnt", 32'(mcnt), 32'(lc_cnt[0]));
      void'(lc_t.pop_front());
      void'(lc_fd.pop_front());
      void'(lc_cnt.pop_front());
    end
    if (mlc) nlc++;
  end

  // model
  task automatic model_clear();
    m_addr = 0; m_y = 0; m_in_frame = 0; m_frame_ovf = 0; m_cnt = '0; m_wrote = 0;
    exp_q.delete(); exp_t.delete();
    lc_t.delete(); lc_fd.delete(); lc_cnt.delete();
  endtask

  task automatic model_pixel(input int x, input logic [15:0] px);
    m_wrote = 0;
    if (!m_in_frame) return;
    if (x < p_srcw && m_y < p_srch && (x % p_dec) == 0 && (m_y % p_dec) == 0) begin
      if (m_addr < p_npix) begin
        exp_q.push_back({17'(m_addr), px});
        exp_t.push_back(ncyc + 1);
        m_addr++;
        m_wrote = 1;
      end else begin
        m_frame_ovf = 1;
      end
    end
  endtask

  task automatic model_rise(input bit wrote_now);
    bit fd;
    fd = m_in_frame && (m_addr == p_npix) && !m_frame_ovf;
    if (fd) m_cnt = m_cnt + 8'd1;
    lc_t.push_back(ncyc + (wrote_now ? 2 : 1));
    lc_fd.push_back(fd);
    lc_cnt.push_back(m_cnt);
    m_addr = 0; m_y = 0; m_frame_ovf = 0; m_in_frame = 1;
  endtask

  // driver tasks
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic fill_buf(input int seed, input int n);
    for (int i = 0; i < n; i++) line_buf[i] = 8'((seed * 29 + i * 13 + 7) & 255);
  endtask

  task automatic send_line(input int n, input bit end_line, input bit rise_last);
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      d = line_buf[i];
      if (rise_last && i == n - 1) vsync = 1'b1;
      step();
      if (i % 2 == 1) model_pixel(i / 2, {line_buf[i-1], line_buf[i]});
      else m_wrote = 0;
      if (rise_last && i == n - 1) model_rise(m_wrote);
    end
    if (end_line) begin
      href = 1'b0;
      step();
      m_y++;
    end
  endtask

  task automatic vsync_pulse();
    href = 1'b0; vsync = 1'b1;
    step();
    model_rise(1'b0);
    step();
    vsync = 1'b0;
    step(); step();
  endtask

  task automatic send_frame(input int nlines, input int nbytes, input int seed);
    for (int y = 0; y < nlines; y++) begin
      fill_buf(seed + y, nbytes);
      send_line(nbytes, 1'b1, 1'b0);
      step();
    end
  endtask

  initial begin
    vsync = 1'b1; href = 1'b0; d = '0; sel = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    p_srcw = 16; p_srch = 12; p_dec = 2; p_npix = 48;
    model_clear();
    repeat (3) step();
    rst_a = 1'b0;
    step();

    // reset state, vsync already high
    chk("rst_we", 32'(ifa.we), 0);
    chk("rst_wAddr", 32'(ifa.wAddr), 0);
    chk("rst_wData", 32'(ifa.wData), 0);
    chk("rst_led_clear", 32'(ifa.led_clear), 0);
    chk("rst_frame_done", 32'(ifa.frame_done), 0);
    chk("rst_frame_cnt", 32'(ifa.frame_cnt), 0);
    chk("rst_overflow", 32'(ifa.overflow), 0);
    chk("rst_state", 32'(dbg_a), 0);
    nlc = 0;
    repeat (8) step();
    chk("no_false_clear", 32'(nlc), 0);
    vsync = 1'b0;
    step(); step();
    vsync_pulse();
    chk("first_clear", 32'(nlc), 1);
    chk("state_frame", 32'(dbg_a), 1);

    // one literal line: F800 kept at x=0, x=1 dropped
    nwe = 0;
    line_buf[0] = 8'hF8; line_buf[1] = 8'h00; line_buf[2] = 8'h07; line_buf[3] = 8'hE0;
    send_line(4, 1'b1, 1'b0);
    step();
    chk("lit_we_count", 32'(nwe), 1);
    chk("lit_wData", 32'(last_data), 32'hF800);
    chk("lit_wAddr", 32'(last_addr), 0);
    vsync_pulse();
    chk("short_frame_cnt", 32'(ifa.frame_cnt), 0);

    // full frame
    nwe = 0;
    send_frame(12, 32, 3);
    vsync_pulse();
    chk("full_we_count", 32'(nwe), 48);
    chk("full_last_addr", 32'(last_addr), 47);
    chk("full_frame_cnt", 32'(ifa.frame_cnt), 1);

    // odd-length lines, an over-wide line and two surplus lines
    nwe = 0;
    for (int y = 0; y < 14; y++) begin
      fill_buf(50 + y, (y < 2) ? 33 : (y == 2) ? 36 : 32);
      send_line((y < 2) ? 33 : (y == 2) ? 36 : 32, 1'b1, 1'b0);
      step();
    end
    vsync_pulse();
    chk("tall_we_count", 32'(nwe), 48);
    chk("tall_last_addr", 32'(last_addr), 47);
    chk("tall_overflow", 32'(ifa.overflow), 0);
    chk("tall_frame_cnt", 32'(ifa.frame_cnt), 2);

    // vsync rise on the same edge as a stored pixel
    line_buf[0] = 8'hAB; line_buf[1] = 8'hCD;
    send_line(2, 1'b1, 1'b1);
    vsync = 1'b0;
    repeat (3) step();

    // reset mid-line
    vsync_pulse();
    nwe = 0;
    send_frame(2, 32, 90);
    fill_buf(92, 10);
    send_line(10, 1'b0, 1'b0);
    rst_a = 1'b1; href = 1'b0;
    step();
    chk("pre_reset_writes", 32'(nwe), 11);
    chk("pre_reset_last_addr", 32'(last_addr), 10);
    chk("mid_rst_we", 32'(ifa.we), 0);
    chk("mid_rst_wAddr", 32'(ifa.wAddr), 0);
    chk("mid_rst_state", 32'(dbg_a), 0);
    model_clear();
    step();
    rst_a = 1'b0;
    step();
    vsync_pulse();
    nwe = 0;
    send_frame(1, 32, 120);
    chk("restart_we_count", 32'(nwe), 8);
    chk("restart_last_addr", 32'(last_addr), 7);

    // DEC=1 into a buffer half the needed size
    rst_a = 1'b1; sel = 1'b1;
    p_srcw = 8; p_srch = 8; p_dec = 1; p_npix = 32;
    step();
    rst_b = 1'b0;
    model_clear();
    step();
    vsync_pulse();
    nwe = 0;
    send_frame(8, 16, 200);
    chk("ovf_we_count", 32'(nwe), 32);
    chk("ovf_last_addr", 32'(last_addr), 31);
    chk("ovf_flag", 32'(movf), 1);
    vsync_pulse();
    chk("ovf_frame_cnt", 32'(mcnt), 0);
    send_frame(4, 16, 220);
    vsync_pulse();
    chk("after_ovf_frame_cnt", 32'(mcnt), 1);
    chk("ovf_sticky", 32'(movf), 1);

    repeat (4) step();
    chk("we_queue_drained", 32'(exp_t.size()), 0);
    chk("clear_queue_drained", 32'(lc_t.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
